// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-read-port register file with per-register busy scoreboard and self-clearing init
// Ports: clk, reset (sync, active-high); wr_en/wr_addr/wr_data writeback port (clears busy);
//        rd_addr -> rd_data/rd_busy, NRD combinational read ports; sb_set_en/sb_set_addr mark a
//        destination busy; sb_err sticky double-issue flag; init_done high once the array is cleared.
// Optional: define REGFILE_BYPASS_EN for same-cycle write-through from the writeback port to reads.
module regfile_mp_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                sb_set_en,
    input  logic [AW-1:0]       sb_set_addr,
    output logic                sb_err,
    output logic                init_done
);
    typedef enum logic {CLEAR, RUN} state_e;
    state_e            state_q;
    logic [AW-1:0]     clr_idx_q;
    logic              init_done_q, sb_err_q, sb_err_d;
    logic [NREGS-1:0]  sb_q, sb_d;
    logic [XLEN-1:0]   mem_q [NREGS];
    logic              run, wr_ok, set_ok;
    assign run    = state_q == RUN;
    assign wr_ok  = run && wr_en && wr_addr != '0;
    assign set_ok = run && sb_set_en && sb_set_addr != '0;
    // A set on the same edge as a write to that register wins: a newer producer was issued.
    always_comb begin
        sb_d = sb_q;
        if (wr_ok) sb_d[wr_addr] = 1'b0;
        if (set_ok) sb_d[sb_set_addr] = 1'b1;
    end
    // Double issue is only an error if the pending producer is not retiring on this same edge.
    assign sb_err_d = sb_err_q | (set_ok && sb_q[sb_set_addr] && !(wr_ok && wr_addr == sb_set_addr));
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CLEAR;
            clr_idx_q   <= '0;
            init_done_q <= 1'b0;
            sb_err_q    <= 1'b0;
            sb_q        <= '0;
        end else if (state_q == CLEAR) begin
            clr_idx_q <= clr_idx_q + 1'b1;
            if (clr_idx_q == AW'(NREGS - 1)) begin
                state_q     <= RUN;
                init_done_q <= 1'b1;
            end
        end else begin
            sb_q     <= sb_d;
            sb_err_q <= sb_err_d;
        end
    end
    // The array has no reset; it is zeroed one entry per cycle while in CLEAR.
    always_ff @(posedge clk) begin
        if (!reset && state_q == CLEAR) mem_q[clr_idx_q] <= '0;
        else if (!reset && wr_ok) mem_q[wr_addr] <= wr_data;
    end
    assign sb_err    = sb_err_q;
    assign init_done = init_done_q;
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic          live;
        assign a    = rd_addr[i*AW +: AW];
        assign live = run && a != '0;
`ifdef REGFILE_BYPASS_EN
        logic byp;
        assign byp = wr_ok && wr_addr == a && !(set_ok && sb_set_addr == a);
        assign rd_data[i*XLEN +: XLEN] = !live ? '0 : byp ? wr_data : mem_q[a];
        assign rd_busy[i] = live && !byp && sb_q[a];
`else
        assign rd_data[i*XLEN +: XLEN] = live ? mem_q[a] : '0;
        assign rd_busy[i] = live && sb_q[a];
`endif
    end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: randomized self-checking bench for regfile_mp_sb against a behavioural model
module tb_regfile_mp_sb;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;
    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                wr_en = 1'b0;
    logic [AW-1:0]       wr_addr = '0;
    logic [XLEN-1:0]     wr_data = '0;
    logic [NRD*AW-1:0]   rd_addr = '0;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                sb_set_en = 1'b0;
    logic [AW-1:0]       sb_set_addr = '0;
    logic                sb_err;
    logic                init_done;
    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] m_mem [NREGS];
    bit              m_sb [NREGS];
    int              m_edges;
    bit              m_done, m_err;

    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .sb_err(sb_err), .init_done(init_done)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit bypass(input int a);
`ifdef REGFILE_BYPASS_EN
        return wr_en && a != 0 && int'(wr_addr) == a && !(sb_set_en && int'(sb_set_addr) == a);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_edge();
        if (reset) begin
            m_done = 0; m_edges = 0; m_err = 0;
            foreach (m_sb[k]) m_sb[k] = 0;
        end else if (!m_done) begin
            m_mem[m_edges] = '0;
            m_edges++;
            if (m_edges == NREGS) m_done = 1;
        end else begin
            if (sb_set_en && sb_set_addr != 0 && m_sb[sb_set_addr] && !(wr_en && wr_addr == sb_set_addr))
                m_err = 1;
            if (wr_en && wr_addr != 0) begin
                m_mem[wr_addr] = wr_data;
                m_sb[wr_addr] = 0;
            end
            if (sb_set_en && sb_set_addr != 0) m_sb[sb_set_addr] = 1;
        end
    endfunction

    task automatic step();
        @(negedge clk);
        check("init_done", {31'b0, init_done}, {31'b0, m_done});
        check("sb_err", {31'b0, sb_err}, {31'b0, m_err});
        for (int i = 0; i < NRD; i++) begin
            int a;
            logic [31:0] ed;
            bit eb;
            a  = int'(rd_addr[i*AW +: AW]);
            ed = (!m_done || a == 0) ? 32'h0 : bypass(a) ? wr_data : m_mem[a];
            eb = (!m_done || a == 0 || bypass(a)) ? 1'b0 : m_sb[a];
            check($sformatf("rd_data%0d@x%0d", i, a), rd_data[i*XLEN +: XLEN], ed);
            check($sformatf("rd_busy%0d@x%0d", i, a), {31'b0, rd_busy[i]}, {31'b0, eb});
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit we, input int wa, input logic [31:0] wd, input bit se, input int sa,
                         input int r0, input int r1);
        wr_en = we; wr_addr = AW'(wa); wr_data = wd;
        sb_set_en = se; sb_set_addr = AW'(sa);
        rd_addr = {AW'(r1), AW'(r0)};
        step();
    endtask

    initial begin
        foreach (m_mem[k]) m_mem[k] = '0;
        @(posedge clk);
        model_edge();
        #1;
        repeat (2) step();
        reset = 1'b0;
        for (int n = 0; n < NREGS; n++)
            drive(1, $urandom_range(1, 31), $urandom, 1, $urandom_range(1, 31), n % 4, $urandom_range(0, 31));
        drive(0, 0, 0, 0, 0, 5, 5);
        check("init_done_after_32", {31'b0, init_done}, 32'h1);
        drive(1, 5, 32'hDEADBEEF, 0, 0, 5, 5);
        drive(0, 0, 0, 0, 0, 5, 5);
        check("x5_port0", rd_data[31:0], 32'hDEADBEEF);
        check("x5_port1", rd_data[63:32], 32'hDEADBEEF);
        drive(1, 0, 32'h1234, 0, 0, 0, 5);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 7, 7, 0);
        drive(0, 0, 0, 0, 0, 7, 7);
        drive(1, 7, 32'h55, 0, 0, 7, 1);
        drive(0, 0, 0, 0, 0, 7, 7);
        drive(1, 9, 32'h99, 1, 9, 9, 9);
        drive(0, 0, 0, 0, 0, 9, 9);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 3, 3, 0);
        drive(0, 0, 0, 1, 3, 3, 0);
        drive(0, 0, 0, 0, 0, 3, 0);
        check("sb_err_sticky", {31'b0, sb_err}, 32'h1);
        drive(0, 0, 0, 1, 0, 0, 3);
        drive(1, 4, 32'hA5A5A5A5, 0, 0, 4, 4);
        drive(0, 0, 0, 0, 0, 4, 4);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 3, 0);
        reset = 1'b0;
        for (int n = 0; n < 10; n++) drive(1, 2, $urandom, 0, 0, 2, 3);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 2, 3);
        reset = 1'b0;
        for (int n = 0; n < NREGS; n++) drive(1, 6, $urandom, 1, 6, 6, n);
        check("init_done_restart", {31'b0, init_done}, 32'h1);
        for (int n = 0; n < 3000; n++) begin
            int lim;
            lim = ($urandom_range(0, 3) == 0) ? 31 : 7;
            reset = ($urandom_range(0, 399) == 0);
            drive($urandom_range(0, 1), $urandom_range(0, lim), $urandom, $urandom_range(0, 3) == 0,
                  $urandom_range(0, lim), $urandom_range(0, lim), $urandom_range(0, lim));
        end
        reset = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
